// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states, access sizes, trap causes,
// and decode helpers used when a request is accepted.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS1 = 2'd1,
        BUS2 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] LSU_B = 2'd0;
    localparam logic [1:0] LSU_H = 2'd1;
    localparam logic [1:0] LSU_W = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    // Stores have no unsigned variant; loads reject the 3'b11x encodings.
    function automatic logic lsu_illegal(input logic store, input logic [2:0] funct3);
        return (funct3[1:0] == 2'd3) || (store ? funct3[2] : (funct3[2] & funct3[1]));
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_H) && off[0]) || ((size == LSU_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/riscv_lsu_lanes.sv
// Byte-lane steering for one 32-bit data port; purely combinational (zero latency, no backpressure).
// Produces an 8-lane strobe across two adjacent words so one instance serves both beats of a split access.
module riscv_lsu_lanes
    import riscv_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_sh;
    logic [3:0]  w_base;
    logic [31:0] w_rep;
    logic [31:0] w_word;

    assign w_sh = {i_off, 3'b000};

    always_comb begin
        w_base = 4'b1111;
        w_rep  = i_wdata;
        case (i_size)
            LSU_B: begin
                w_base = 4'b0001;
                w_rep  = {4{i_wdata[7:0]}};
            end
            LSU_H: begin
                w_base = 4'b0011;
                w_rep  = {2{i_wdata[15:0]}};
            end
            default: begin
                w_base = 4'b1111;
                w_rep  = i_wdata;
            end
        endcase
    end

    assign o_wstrb = {4'b0000, w_base} << i_off;

    // Rotating the replicated word equals plain replication for aligned accesses and also places
    // the correct bytes in both words of an access that straddles a word boundary.
    assign o_wdata = (w_rep << w_sh) | (w_rep >> (6'd32 - {1'b0, w_sh}));

    assign w_word = 32'(i_rdata >> w_sh);

    always_comb begin
        o_rdata = w_word;
        case (i_size)
            LSU_B: o_rdata = i_uns ? {24'h0, w_word[7:0]} : {{24{w_word[7]}}, w_word[7:0]};
            LSU_H: o_rdata = i_uns ? {16'h0, w_word[15:0]} : {{16{w_word[15]}}, w_word[15:0]};
            default: o_rdata = w_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, 2-cycle best-case latency, holds mem_valid until mem_ready
// or watchdog expiry; req_ready low while busy. Define RISCV_LSU_SPLIT_EN to split misaligned H/W into two beats.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_trap,
    output logic [1:0]        rsp_cause,
    output logic              mem_valid,
    output logic              mem_instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

`ifdef RISCV_LSU_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic              r_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [4:0]        r_rd;
    logic              r_split;
    logic [31:0]       r_lo;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_wstrb;
    logic              r_rsp_trap;
    logic [1:0]        r_rsp_cause;
    logic [31:0]       r_rsp_rdata;
    logic [4:0]        r_rsp_rd;

    logic              w_idle;
    logic [1:0]        w_off;
    logic [1:0]        w_size;
    logic              w_uns;
    logic              w_illegal;
    logic              w_misal;
    logic              w_tmo;
    logic              w_enter_resp;
    logic [1:0]        w_cause;
    logic [63:0]       w_rd64;
    logic [7:0]        w_strb8;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_lane_rdata;

    assign w_idle    = (r_state == IDLE);
    // The lane block sees the live request while idle and the latched one during the bus beats.
    assign w_off     = w_idle ? req_addr[1:0]     : r_off;
    assign w_size    = w_idle ? req_funct3[1:0]   : r_funct3[1:0];
    assign w_uns     = w_idle ? req_funct3[2]     : r_funct3[2];
    assign w_illegal = lsu_illegal(req_store, req_funct3);
    assign w_misal   = lsu_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign w_rd64    = (r_state == BUS2) ? {mem_rdata, r_lo} : {32'h0, mem_rdata};
    // Fires on the last permitted wait cycle; a simultaneous mem_ready takes priority.
    assign w_tmo     = (TIMEOUT != 0) && !mem_ready && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

    riscv_lsu_lanes u_lanes (
        .i_off   (w_off),
        .i_size  (w_size),
        .i_uns   (w_uns),
        .i_wdata (req_wdata),
        .i_rdata (w_rd64),
        .o_wstrb (w_strb8),
        .o_wdata (w_lane_wdata),
        .o_rdata (w_lane_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause     = CAUSE_NONE;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_state_nxt = RESP;
                        w_cause     = CAUSE_ILLEGAL;
                    end else if (w_misal && !SPLIT_EN) begin
                        w_state_nxt = RESP;
                        w_cause     = CAUSE_MISALIGN;
                    end else begin
                        w_state_nxt = BUS1;
                    end
                end
            end
            BUS1: begin
                if (mem_ready) begin
                    w_state_nxt = r_split ? BUS2 : RESP;
                end else if (w_tmo) begin
                    w_state_nxt = RESP;
                    w_cause     = CAUSE_TIMEOUT;
                end
            end
            BUS2: begin
                if (mem_ready) begin
                    w_state_nxt = RESP;
                end else if (w_tmo) begin
                    w_state_nxt = RESP;
                    w_cause     = CAUSE_TIMEOUT;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = w_idle && !reset;
        mem_valid = (r_state == BUS1) || (r_state == BUS2);
        rsp_valid = (r_state == RESP);
    end

    assign mem_instr = 1'b0;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_trap  = r_rsp_trap;
    assign rsp_cause = r_rsp_cause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store     <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_rd        <= 5'd0;
            r_split     <= 1'b0;
            r_lo        <= 32'h0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
            r_rsp_trap  <= 1'b0;
            r_rsp_cause <= CAUSE_NONE;
            r_rsp_rdata <= 32'h0;
            r_rsp_rd    <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_funct3    <= req_funct3;
                        r_off       <= req_addr[1:0];
                        r_rd        <= req_rd;
                        r_split     <= w_misal && SPLIT_EN;
                        r_cnt       <= '0;
                        r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_wstrb <= req_store ? w_strb8[3:0] : 4'h0;
                        r_mem_wdata <= req_store ? w_lane_wdata : 32'h0;
                    end
                end
                BUS1, BUS2: begin
                    if (mem_ready) begin
                        r_cnt <= '0;
                        r_lo  <= mem_rdata;
                        if ((r_state == BUS1) && r_split) begin
                            r_mem_addr  <= r_mem_addr + ADDR_W'(4);
                            r_mem_wstrb <= r_store ? w_strb8[7:4] : 4'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (w_enter_resp) begin
                r_rsp_trap  <= (w_cause != CAUSE_NONE);
                r_rsp_cause <= w_cause;
                r_rsp_rd    <= w_idle ? req_rd : r_rd;
                r_rsp_rdata <= ((w_cause == CAUSE_NONE) && !r_store) ? w_lane_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed cases plus random loads/stores against a byte-array reference memory.
module tb_riscv_lsu;

    localparam int TMO = 4;
`ifdef RISCV_LSU_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_trap;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_cause;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_chk = 0;
    int n_err = 0;
    int op_id = 0;

    logic [31:0] dev  [0:7];
    logic [7:0]  refm [0:31];

    int          obs_cyc, obs_beats, obs_vcnt;
    logic [31:0] obs_rdata;
    logic        obs_trap, obs_after, obs_rdy, obs_instr;
    logic [1:0]  obs_cause;
    logic [4:0]  obs_rd;
    logic [31:0] b_addr  [0:1];
    logic [31:0] b_wdata [0:1];
    logic [3:0]  b_strb  [0:1];

    always #5 clk = ~clk;

    riscv_lsu #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
        .rsp_trap(rsp_trap), .rsp_cause(rsp_cause),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (op %0d): observed %h expected %h", tag, op_id, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        dev[idx] = w;
        for (int b = 0; b < 4; b++) refm[idx*4 + b] = w[8*b +: 8];
    endtask

    // Drives one request and plays the memory slave: mem_ready after `lat` wait cycles per beat.
    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int lat);
        int w;
        int idx;
        bit done;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom; req_rd = 5'($urandom);
        obs_cyc = -1; obs_beats = 0; obs_vcnt = 0; obs_instr = 1'b0; obs_after = 1'b1; obs_rdy = 1'b0;
        w = 0; done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            mem_ready = 1'b0;
            if (mem_instr !== 1'b0) obs_instr = 1'b1;
            if (rsp_valid) begin
                obs_cyc = c; obs_rdata = rsp_rdata; obs_trap = rsp_trap;
                obs_cause = rsp_cause; obs_rd = rsp_rd;
                done = 1'b1;
            end else if (mem_valid) begin
                obs_vcnt++;
                if (w == lat) begin
                    idx = int'(mem_addr[4:2]);
                    mem_ready = 1'b1;
                    mem_rdata = dev[idx];
                    if (obs_beats < 2) begin
                        b_addr[obs_beats] = mem_addr; b_wdata[obs_beats] = mem_wdata;
                        b_strb[obs_beats] = mem_wstrb;
                    end
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) dev[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    obs_beats++;
                    w = 0;
                end else begin
                    w++;
                    mem_rdata = $urandom;
                end
            end
            if (!done) @(negedge clk);
        end
        if (done) begin
            @(negedge clk);
            obs_after = rsp_valid;
            obs_rdy   = req_ready;
        end
    endtask

    task automatic op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd, input int lat);
        int n, off, nb, e_cyc, e_vcnt, base;
        bit ill, mis;
        logic [1:0]  e_cause;
        logic [31:0] e_rd, v, m, ew;
        op_id++;
        n    = 1 << f3[1:0];
        off  = int'(addr[1:0]);
        base = int'(addr[4:0]);
        ill  = (f3[1:0] == 2'd3) || (st ? f3[2] : (f3[2] && f3[1]));
        mis  = !ill && ((off % n) != 0);
        e_rd = 32'h0; nb = 0; e_vcnt = 0;
        if (ill) begin
            e_cause = 2'd3; e_cyc = 1;
        end else if (mis && !SPLIT) begin
            e_cause = 2'd1; e_cyc = 1;
        end else if (lat >= TMO) begin
            e_cause = 2'd2; e_cyc = TMO + 1; e_vcnt = TMO;
        end else begin
            e_cause = 2'd0;
            nb      = mis ? 2 : 1;
            e_cyc   = nb * (lat + 1) + 1;
            e_vcnt  = nb * (lat + 1);
            v = 32'h0;
            for (int i = 0; i < n; i++) v |= 32'(refm[(base + i) % 32]) << (8 * i);
            if (st) begin
                for (int i = 0; i < n; i++) refm[(base + i) % 32] = wd[8*i +: 8];
            end else begin
                if (n == 1 && !f3[2] && v[7])  v |= 32'hFFFFFF00;
                if (n == 2 && !f3[2] && v[15]) v |= 32'hFFFF0000;
                e_rd = v;
            end
        end
        txn(st, f3, addr, wd, rd, lat);
        chk("rsp_cycle", obs_cyc, e_cyc);
        chk("rsp_trap", obs_trap, (e_cause != 2'd0));
        chk("rsp_cause", obs_cause, e_cause);
        chk("rsp_rdata", obs_rdata, e_rd);
        chk("rsp_rd", obs_rd, rd);
        chk("bus_beats", obs_beats, nb);
        chk("valid_cycles", obs_vcnt, e_vcnt);
        chk("rsp_one_cycle", obs_after, 1'b0);
        chk("ready_after", obs_rdy, 1'b1);
        chk("mem_instr", obs_instr, 1'b0);
        if (nb == 1) begin
            chk("beat_addr", b_addr[0], {addr[31:2], 2'b00});
            chk("beat_strb", b_strb[0], st ? (((32'd1 << n) - 1) << off) : 32'd0);
            if (st) begin
                m = 32'h0; ew = 32'h0;
                for (int i = 0; i < n; i++) begin
                    m[8*(off+i) +: 8]  = 8'hFF;
                    ew[8*(off+i) +: 8] = wd[8*i +: 8];
                end
                chk("beat_wdata", b_wdata[0] & m, ew);
            end
        end else if (nb == 2) begin
            chk("beat2_addr", b_addr[1], b_addr[0] + 32'd4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit seen;
        bit          st;
        logic [2:0]  f3;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_ready = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 8; i++) set_word(i, $urandom);

        repeat (2) @(negedge clk);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_instr", mem_instr, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", mem_wstrb, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_trap", rsp_trap, 1'b0);
        chk("rst_rsp_cause", rsp_cause, 2'd0);
        chk("rst_rsp_rd", rsp_rd, 5'd0);
        chk("rst_req_ready", req_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1'b1);

        set_word(0, 32'hDEADBEEF);
        op(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 0);
        chk("lw_rdata", obs_rdata, 32'hDEADBEEF);
        chk("lw_strb", b_strb[0], 4'b0000);
        chk("lw_latency", obs_cyc, 2);

        set_word(0, 32'h80FF_0000);
        op(1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 1);
        chk("lb_rdata", obs_rdata, 32'hFFFFFF80);
        op(1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 0);
        chk("lbu_rdata", obs_rdata, 32'h00000080);

        op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd9, 0);
        chk("sh_addr", b_addr[0], 32'h200);
        chk("sh_strb", b_strb[0], 4'b1100);
        chk("sh_wdata", b_wdata[0], 32'hABCDABCD);

        set_word(0, 32'h44332211);
        set_word(1, 32'h88776655);
        op(1'b0, 3'b010, 32'h101, 32'h0, 5'd11, 0);
        if (SPLIT) begin
            chk("split_rdata", obs_rdata, 32'h55443322);
            chk("split_addr1", b_addr[0], 32'h100);
            chk("split_addr2", b_addr[1], 32'h104);
        end else begin
            chk("misal_cause", obs_cause, 2'd1);
            chk("misal_no_beat", obs_vcnt, 0);
        end

        op(1'b1, 3'b011, 32'h104, 32'h55, 5'd1, 0);
        op(1'b0, 3'b110, 32'h104, 32'h0, 5'd2, 0);
        op(1'b1, 3'b100, 32'h104, 32'h55, 5'd2, 0);

        op(1'b0, 3'b010, 32'h108, 32'h0, 5'd5, 100);
        chk("tmo_cause", obs_cause, 2'd2);
        chk("tmo_valid_cycles", obs_vcnt, TMO);
        op(1'b0, 3'b010, 32'h108, 32'h0, 5'd6, TMO - 1);
        chk("late_ready_trap", obs_trap, 1'b0);
        op(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 5'd8, 100);

        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd1;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b0;
        chk("mid_valid_before", mem_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid_async", mem_valid, 1'b0);
        chk("mid_ready_in_rst", req_ready, 1'b0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        reset = 1'b0;
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
        chk("mid_no_rsp", seen, 1'b0);
        chk("mid_ready_after", req_ready, 1'b1);

        for (int k = 0; k < 60; k++) begin
            st = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            if (($urandom % 4) != 0)
                f3 = st ? {1'b0, 2'($urandom % 3)} : {1'($urandom % 2), 2'($urandom % 3)};
            op(st, f3, 32'h100 + ($urandom % 32), $urandom, 5'($urandom), int'($urandom % 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
